pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/pipe_entry.sv | 47 ++++
 rtl/pipe_stage_reg.sv | 206 ++++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the CPU pipeline slice.
//   - Default widths of the pipeline register fields (control, data, dest).
//   - Bit positions of the individual control signals inside the ctrl field.
//   - State encoding of a pipeline stage register and a helper that maps a
//     state to the number of beats it holds.
// ---------------------------------------------------------------------------
package cpu_pkg;

  // Default field widths
  localparam int CPU_CTRL_W = 32'sd6;
  localparam int CPU_DATA_W = 32'sd32;
  localparam int CPU_ADDR_W = 32'sd4;

  // Control field layout: {reg_write, mem_write, mem_to_reg, alu_src, alu_ctl[1:0]}
  localparam int CTRL_REG_WRITE_BIT  = 32'sd5;
  localparam int CTRL_MEM_WRITE_BIT  = 32'sd4;
  localparam int CTRL_MEM_TO_REG_BIT = 32'sd3;
  localparam int CTRL_ALU_SRC_BIT    = 32'sd2;
  localparam int CTRL_ALU_CTL_MSB    = 32'sd1;
  localparam int CTRL_ALU_CTL_LSB    = 32'sd0;

  // Stage state; the encoding equals the number of held beats
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  // Number of beats held in a given state
  function automatic logic [1:0] state_to_occ(input stage_state_e st);
    logic [1:0] occ;
    case (st)
      ST_EMPTY: occ = 2'd0;
      ST_ONE:   occ = 2'd1;
      ST_TWO:   occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// ---------------------------------------------------------------------------
// pipe_entry
//   One pipeline beat register (ctrl, data, waddr held together).
//   Ports:
//     clk, reset        - clock, asynchronous active-high reset (clears beat)
//     load              - capture d_* on the rising edge
//     clear             - zero the beat on the rising edge (wins over load)
//     d_ctrl/d_data/d_waddr - beat to capture
//     q_ctrl/q_data/q_waddr - held beat
// ---------------------------------------------------------------------------
module pipe_entry
  import cpu_pkg::*;
#(
  parameter int CTRL_W = CPU_CTRL_W,
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  input  logic [ADDR_W-1:0] d_waddr,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data,
  output logic [ADDR_W-1:0] q_waddr
);

  // Beat storage: clear has priority so an empty entry always reads as zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_ctrl  <= '0;
      q_data  <= '0;
      q_waddr <= '0;
    end else if (clear) begin
      q_ctrl  <= '0;
      q_data  <= '0;
      q_waddr <= '0;
    end else if (load) begin
      q_ctrl  <= d_ctrl;
      q_data  <= d_data;
      q_waddr <= d_waddr;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Valid/ready pipeline stage register carrying {ctrl, data, waddr}.
//   SKID=1: two entries (head + skid), in_ready is a register output.
//   SKID=0: one entry, in_ready = out_ready || !out_valid.
//   Ports:
//     clk, reset            - clock, asynchronous active-high reset
//     in_valid/in_ready     - upstream handshake
//     in_ctrl/data/waddr    - incoming beat
//     flush                 - synchronous squash of every held/incoming beat
//     out_valid/out_ready   - downstream handshake
//     out_ctrl/data/waddr   - oldest held beat, all-zero when out_valid=0
//     occupancy             - number of held beats (0..2)
// ---------------------------------------------------------------------------
module pipe_stage_reg
  import cpu_pkg::*;
#(
  parameter int CTRL_W = CPU_CTRL_W,
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int SKID   = 32'sd1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_waddr,
  output logic [1:0]        occupancy
);

  stage_state_e      state_r;
  stage_state_e      state_next_s;
  logic              out_valid_r;
  logic [1:0]        occupancy_r;
  logic              in_ready_r;

  logic              accept_s;
  logic              emit_s;
  logic              head_load_s;
  logic              head_clear_s;
  logic              head_sel_skid_s;
  logic              skid_load_s;
  logic              skid_clear_s;

  logic [CTRL_W-1:0] head_d_ctrl_s;
  logic [DATA_W-1:0] head_d_data_s;
  logic [ADDR_W-1:0] head_d_waddr_s;
  logic [CTRL_W-1:0] skid_q_ctrl_s;
  logic [DATA_W-1:0] skid_q_data_s;
  logic [ADDR_W-1:0] skid_q_waddr_s;

  assign accept_s  = in_valid && in_ready;
  assign emit_s    = out_valid_r && out_ready;
  assign out_valid = out_valid_r;
  assign occupancy = occupancy_r;

  // Next-state and entry load/clear decode; flush overrides everything
  always_comb begin
    state_next_s    = state_r;
    head_load_s     = 1'b0;
    head_clear_s    = 1'b0;
    head_sel_skid_s = 1'b0;
    skid_load_s     = 1'b0;
    skid_clear_s    = 1'b0;
    if (flush) begin
      state_next_s = ST_EMPTY;
      head_clear_s = 1'b1;
      skid_clear_s = 1'b1;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            head_load_s  = 1'b1;
            state_next_s = ST_ONE;
          end else begin
            state_next_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && emit_s) begin
            // Old beat leaves while the new one takes its place
            head_load_s  = 1'b1;
            state_next_s = ST_ONE;
          end else if (accept_s) begin
            // Only reachable with a skid entry: pass-through ready
            // guarantees an emit whenever ONE accepts
            if (SKID != 32'sd0) begin
              skid_load_s  = 1'b1;
              state_next_s = ST_TWO;
            end else begin
              state_next_s = ST_ONE;
            end
          end else if (emit_s) begin
            head_clear_s = 1'b1;
            state_next_s = ST_EMPTY;
          end else begin
            state_next_s = ST_ONE;
          end
        end
        ST_TWO: begin
          if (emit_s) begin
            // Skid beat moves up to the output on the same edge
            head_load_s     = 1'b1;
            head_sel_skid_s = 1'b1;
            skid_clear_s    = 1'b1;
            state_next_s    = ST_ONE;
          end else begin
            state_next_s = ST_TWO;
          end
        end
        default: begin
          state_next_s = ST_EMPTY;
          head_clear_s = 1'b1;
          skid_clear_s = 1'b1;
        end
      endcase
    end
  end

  // Head entry source: the skid entry when draining TWO, otherwise the input
  always_comb begin
    if (head_sel_skid_s) begin
      head_d_ctrl_s  = skid_q_ctrl_s;
      head_d_data_s  = skid_q_data_s;
      head_d_waddr_s = skid_q_waddr_s;
    end else begin
      head_d_ctrl_s  = in_ctrl;
      head_d_data_s  = in_data;
      head_d_waddr_s = in_waddr;
    end
  end

  // Stage FSM with registered valid, occupancy and ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      occupancy_r <= 2'd0;
      in_ready_r  <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      out_valid_r <= (state_next_s != ST_EMPTY);
      occupancy_r <= state_to_occ(state_next_s);
      in_ready_r  <= (state_next_s != ST_TWO);
    end
  end

  pipe_entry #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_head_entry (
    .clk     (clk),
    .reset   (reset),
    .load    (head_load_s),
    .clear   (head_clear_s),
    .d_ctrl  (head_d_ctrl_s),
    .d_data  (head_d_data_s),
    .d_waddr (head_d_waddr_s),
    .q_ctrl  (out_ctrl),
    .q_data  (out_data),
    .q_waddr (out_waddr)
  );

  generate
    if (SKID != 32'sd0) begin : g_skid
      assign in_ready = in_ready_r;

      pipe_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
      ) u_skid_entry (
        .clk     (clk),
        .reset   (reset),
        .load    (skid_load_s),
        .clear   (skid_clear_s),
        .d_ctrl  (in_ctrl),
        .d_data  (in_data),
        .d_waddr (in_waddr),
        .q_ctrl  (skid_q_ctrl_s),
        .q_data  (skid_q_data_s),
        .q_waddr (skid_q_waddr_s)
      );
    end else begin : g_pass
      logic skid_unused_s;

      // in_ready_r is 0 in reset and 1 afterwards (TWO is never entered),
      // so it keeps in_ready low while reset is held
      assign in_ready       = in_ready_r && (out_ready || !out_valid_r);
      assign skid_q_ctrl_s  = '0;
      assign skid_q_data_s  = '0;
      assign skid_q_waddr_s = '0;
      assign skid_unused_s  = skid_load_s ^ skid_clear_s;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Directed bench for pipe_stage_reg: one SKID=1 instance (s_*) and one
//   SKID=0 instance (p_*) sharing clock and reset.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset;

  logic        s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready;
  logic [5:0]  s_in_ctrl, s_out_ctrl;
  logic [31:0] s_in_data, s_out_data;
  logic [3:0]  s_in_waddr, s_out_waddr;
  logic [1:0]  s_occupancy;

  logic        p_in_valid, p_in_ready, p_flush, p_out_valid, p_out_ready;
  logic [5:0]  p_in_ctrl, p_out_ctrl;
  logic [31:0] p_in_data, p_out_data;
  logic [3:0]  p_in_waddr, p_out_waddr;
  logic [1:0]  p_occupancy;

  int checks;
  int errors;

  pipe_stage_reg #(.CTRL_W(6), .DATA_W(32), .ADDR_W(4), .SKID(1)) u_skid (
    .clk(clk), .reset(reset),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_ctrl(s_in_ctrl), .in_data(s_in_data), .in_waddr(s_in_waddr),
    .flush(s_flush),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_ctrl(s_out_ctrl), .out_data(s_out_data), .out_waddr(s_out_waddr),
    .occupancy(s_occupancy)
  );

  pipe_stage_reg #(.CTRL_W(6), .DATA_W(32), .ADDR_W(4), .SKID(0)) u_pass (
    .clk(clk), .reset(reset),
    .in_valid(p_in_valid), .in_ready(p_in_ready),
    .in_ctrl(p_in_ctrl), .in_data(p_in_data), .in_waddr(p_in_waddr),
    .flush(p_flush),
    .out_valid(p_out_valid), .out_ready(p_out_ready),
    .out_ctrl(p_out_ctrl), .out_data(p_out_data), .out_waddr(p_out_waddr),
    .occupancy(p_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic s_drive(input logic v, input logic [5:0] c, input logic [31:0] d, input logic [3:0] a);
    s_in_valid = v;
    s_in_ctrl  = c;
    s_in_data  = d;
    s_in_waddr = a;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", s_out_valid); end
    checks++; if (s_occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", s_occupancy); end
    checks++; if ({s_out_ctrl, s_out_data, s_out_waddr} !== 42'd0) begin errors++; $display("FAIL reset_fields: got %h want 0", {s_out_ctrl, s_out_data, s_out_waddr}); end
    checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL reset_s_in_ready: got %b want 0", s_in_ready); end
    checks++; if (p_in_ready !== 1'b0) begin errors++; $display("FAIL reset_p_in_ready: got %b want 0", p_in_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL release_s_in_ready: got %b want 0", s_in_ready); end
    step();
    checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_s_in_ready: got %b want 1", s_in_ready); end
    checks++; if (p_in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_p_in_ready: got %b want 1", p_in_ready); end
  endtask

  task automatic test_single_beat();
    s_out_ready = 1'b1;
    s_drive(1'b1, 6'b101101, 32'h0000_00FF, 4'd3);
    step();
    s_drive(1'b0, 6'd0, 32'd0, 4'd0);
    checks++; if (s_out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", s_out_valid); end
    checks++; if (s_out_ctrl !== 6'b101101) begin errors++; $display("FAIL single_ctrl: got %b want 101101", s_out_ctrl); end
    checks++; if (s_out_data !== 32'h0000_00FF) begin errors++; $display("FAIL single_data: got %h want 000000ff", s_out_data); end
    checks++; if (s_out_waddr !== 4'd3) begin errors++; $display("FAIL single_waddr: got %0d want 3", s_out_waddr); end
    checks++; if (s_occupancy !== 2'd1) begin errors++; $display("FAIL single_occ: got %0d want 1", s_occupancy); end
    step();
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid: got %b want 0", s_out_valid); end
    checks++; if ({s_out_ctrl, s_out_data, s_out_waddr} !== 42'd0) begin errors++; $display("FAIL single_bubble: got %h want 0", {s_out_ctrl, s_out_data, s_out_waddr}); end
  endtask

  task automatic test_fill_skid();
    s_out_ready = 1'b0;
    s_drive(1'b1, 6'b100001, 32'hA0A0_0001, 4'h1);
    step();
    s_drive(1'b1, 6'b010010, 32'hB0B0_0002, 4'h2);
    step();
    s_drive(1'b1, 6'b001100, 32'hC0C0_0003, 4'h3);
    step();
    checks++; if (s_occupancy !== 2'd2) begin errors++; $display("FAIL fill_occ: got %0d want 2", s_occupancy); end
    checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b want 0", s_in_ready); end
    checks++; if (s_out_data !== 32'hA0A0_0001) begin errors++; $display("FAIL fill_head_stable: got %h want a0a00001", s_out_data); end
    s_drive(1'b0, 6'd0, 32'd0, 4'd0);
    s_out_ready = 1'b1;
    step();
    checks++; if ({s_out_valid, s_out_ctrl, s_out_data, s_out_waddr} !== {1'b1, 6'b010010, 32'hB0B0_0002, 4'h2}) begin
      errors++; $display("FAIL fill_second_beat: got %b %b %h %h want 1 010010 b0b00002 2", s_out_valid, s_out_ctrl, s_out_data, s_out_waddr);
    end
    checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_back: got %b want 1", s_in_ready); end
    checks++; if (s_occupancy !== 2'd1) begin errors++; $display("FAIL fill_occ_one: got %0d want 1", s_occupancy); end
    step();
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL fill_third_not_accepted: got %b want 0", s_out_valid); end
  endtask

  task automatic test_streaming();
    logic [31:0] d;
    s_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = 32'h5000_0000 + 32'(i);
      s_drive(1'b1, 6'(i + 1), d, 4'(i));
      step();
      checks++; if ({s_out_valid, s_out_data, s_in_ready, s_occupancy} !== {1'b1, d, 1'b1, 2'd1}) begin
        errors++; $display("FAIL stream_%0d: got valid=%b data=%h rdy=%b occ=%0d want 1 %h 1 1", i, s_out_valid, s_out_data, s_in_ready, s_occupancy, d);
      end
    end
    s_drive(1'b0, 6'd0, 32'd0, 4'd0);
    step();
    checks++; if (s_occupancy !== 2'd0) begin errors++; $display("FAIL stream_drain_occ: got %0d want 0", s_occupancy); end
  endtask

  task automatic test_flush();
    s_out_ready = 1'b0;
    s_drive(1'b1, 6'b100001, 32'hA0A0_0001, 4'h1);
    step();
    s_drive(1'b1, 6'b010010, 32'hB0B0_0002, 4'h2);
    step();
    checks++; if (s_occupancy !== 2'd2) begin errors++; $display("FAIL flush_pre_occ: got %0d want 2", s_occupancy); end
    s_flush = 1'b1;
    s_drive(1'b1, 6'b111111, 32'hDDDD_0004, 4'h4);
    step();
    s_flush = 1'b0;
    s_drive(1'b0, 6'd0, 32'd0, 4'd0);
    checks++; if ({s_occupancy, s_out_valid, s_out_ctrl} !== {2'd0, 1'b0, 6'd0}) begin
      errors++; $display("FAIL flush_two: got occ=%0d valid=%b ctrl=%b want 0 0 0", s_occupancy, s_out_valid, s_out_ctrl);
    end
    checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", s_in_ready); end
    s_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost_%0d: got %b want 0", i, s_out_valid); end
    end
    // Flush in ONE together with an accept
    s_out_ready = 1'b0;
    s_drive(1'b1, 6'b100001, 32'hA0A0_0001, 4'h1);
    step();
    s_flush = 1'b1;
    s_drive(1'b1, 6'b010010, 32'hB0B0_0002, 4'h2);
    step();
    s_flush = 1'b0;
    s_drive(1'b0, 6'd0, 32'd0, 4'd0);
    checks++; if ({s_occupancy, s_out_valid, s_out_data} !== {2'd0, 1'b0, 32'd0}) begin
      errors++; $display("FAIL flush_one_accept: got occ=%0d valid=%b data=%h want 0 0 0", s_occupancy, s_out_valid, s_out_data);
    end
  endtask

  task automatic test_pass_toggle();
    logic [7:0]  pat;
    logic        model_valid;
    logic [31:0] model_data;
    int          idx;
    logic        orv;
    logic        ivv;
    pat         = 8'b0101_0101;
    model_valid = 1'b0;
    model_data  = 32'd0;
    idx         = 0;
    for (int c = 0; c < 8; c++) begin
      orv = pat[c];
      ivv = (idx < 3);
      p_out_ready = orv;
      p_in_valid  = ivv;
      p_in_ctrl   = 6'(idx + 8);
      p_in_data   = 32'hD000_0000 + 32'(idx);
      p_in_waddr  = 4'(idx + 5);
      #1;
      checks++; if (p_in_ready !== (orv || !model_valid)) begin
        errors++; $display("FAIL pass_ready_c%0d: got %b want %b", c, p_in_ready, (orv || !model_valid));
      end
      if (model_valid) begin
        checks++; if ({p_out_valid, p_out_data} !== {1'b1, model_data}) begin
          errors++; $display("FAIL pass_data_c%0d: got valid=%b data=%h want 1 %h", c, p_out_valid, p_out_data, model_data);
        end
      end
      if (ivv && (orv || !model_valid)) begin
        model_data  = 32'hD000_0000 + 32'(idx);
        model_valid = 1'b1;
        idx++;
      end else if (model_valid && orv) begin
        model_valid = 1'b0;
      end
      step();
    end
    p_in_valid  = 1'b0;
    p_out_ready = 1'b0;
    checks++; if ({p_out_valid, p_occupancy, p_out_data} !== {1'b0, 2'd0, 32'd0}) begin
      errors++; $display("FAIL pass_drained: got valid=%b occ=%0d data=%h want 0 0 0", p_out_valid, p_occupancy, p_out_data);
    end
  endtask

  task automatic test_reset_midop();
    s_out_ready = 1'b0;
    s_drive(1'b1, 6'b100001, 32'hA0A0_0001, 4'h1);
    step();
    s_drive(1'b1, 6'b010010, 32'hB0B0_0002, 4'h2);
    step();
    s_drive(1'b0, 6'd0, 32'd0, 4'd0);
    checks++; if (s_occupancy !== 2'd2) begin errors++; $display("FAIL midrst_pre_occ: got %0d want 2", s_occupancy); end
    reset = 1'b1;
    #1;
    checks++; if ({s_out_valid, s_out_ctrl, s_out_data, s_out_waddr, s_occupancy, s_in_ready} !== 46'd0) begin
      errors++; $display("FAIL midrst_async: got valid=%b ctrl=%b data=%h waddr=%h occ=%0d rdy=%b want all 0",
                         s_out_valid, s_out_ctrl, s_out_data, s_out_waddr, s_occupancy, s_in_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL midrst_release_ready: got %b want 0", s_in_ready); end
    step();
    checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_after: got %b want 1", s_in_ready); end
    s_out_ready = 1'b1;
    step();
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_emit: got %b want 0", s_out_valid); end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    s_flush     = 1'b0;
    s_out_ready = 1'b0;
    s_drive(1'b0, 6'd0, 32'd0, 4'd0);
    p_flush     = 1'b0;
    p_out_ready = 1'b0;
    p_in_valid  = 1'b0;
    p_in_ctrl   = 6'd0;
    p_in_data   = 32'd0;
    p_in_waddr  = 4'd0;

    test_reset();
    test_single_beat();
    test_fill_skid();
    test_streaming();
    test_flush();
    test_pass_toggle();
    test_reset_midop();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
